modulator_frame_ctrl: RTL and testbench
=======================================

// Module: modulator_frame_ctrl
// PURPOSE
//  Frame sequencer in front of Modulator. Takes a start command and a payload byte stream.
//  Emits preamble, a 2-byte length header, the payload, an optional CRC and guard padding
//  as bytes on a valid/ready link into the Modulator byte input (i_data/i_valid_input/o_ready).
//  Reports frame completion, aborts, rejected starts and upstream underruns.
// PARAMETERS
//  LEN_W          16    width of frame payload length, in bytes
//  PREAMBLE_LEN   4     preamble byte count (>=1)
//  PREAMBLE_BYTE  8'h55 preamble byte value
//  GUARD_LEN      2     trailing 8'h00 pad byte count (0 = none)
//  UNDR_W         16    underrun counter width
// PORTS
//  i_clk          in   1      clock
//  i_reset_n      in   1      asynchronous active-low reset
//  i_start        in   1      frame request pulse; sampled only in IDLE
//  i_length       in   LEN_W  payload byte count, sampled with i_start
//  i_abort        in   1      abandon current frame
//  i_data         in   8      payload byte from source
//  i_valid        in   1      source byte valid
//  o_ready        out  1      controller accepts payload byte
//  o_mod_data     out  8      byte to Modulator
//  o_mod_valid    out  1      byte valid to Modulator
//  i_mod_ready    in   1      Modulator ready (its o_ready)
//  o_busy         out  1      state != IDLE
//  o_done         out  1      1-cycle pulse: last guard byte (or CRC/last payload if GUARD_LEN=0) accepted
//  o_aborted      out  1      1-cycle pulse on abort
//  o_error        out  1      1-cycle pulse: i_start with i_length==0
//  o_underrun_cnt out  UNDR_W saturating count of PAYLOAD stall cycles caused by source
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; asserting i_reset_n low mid-frame drops o_mod_valid immediately.
//  Handshake:
//   - a byte transfers on o_mod_valid && i_mod_ready; o_mod_data is held stable while valid && !ready.
//   - the output register loads when !o_mod_valid || i_mod_ready.
//  States: IDLE -> PRE -> HDR -> PAY -> [CRC] -> GUARD -> IDLE; byte counter reloads on each entry.
//   - IDLE: i_start && i_length!=0 latches length; o_mod_valid=1 next cycle carrying PREAMBLE_BYTE.
//     i_start && i_length==0: o_error pulse, stay IDLE. i_start outside IDLE is ignored.
//   - PRE: PREAMBLE_LEN bytes. HDR: length[15:8] then length[7:0] (LEN_W>8: MSB byte first, zero-extended to 16 bits).
//   - PAY: o_ready = (state==PAY) && (!o_mod_valid || i_mod_ready) && bytes_left!=0.
//     Each i_valid&&o_ready transfer loads the output register; bytes_left decrements.
//     Cycle with output register free && !i_valid: o_mod_valid=0 (bubble), o_underrun_cnt+1, saturating at all-ones.
//   - GUARD: GUARD_LEN bytes of 8'h00; o_done pulses in the cycle the last byte is accepted; next state IDLE.
//     GUARD_LEN=0: o_done on the final PAY/CRC byte acceptance.
//  Boundaries:
//   - o_mod_valid stays asserted back-to-back across state transitions (no bubble) when i_mod_ready stays high.
//   - Throughput is 1 byte/cycle.
//   - i_abort in any non-IDLE state: next cycle o_mod_valid=0, o_ready=0, state IDLE, o_aborted pulse, no o_done.
//     Abort deliberately discards an unaccepted byte. i_abort in IDLE is ignored. i_abort has priority over i_start.
//   - o_underrun_cnt clears only on reset.
// CONFIGURATION
//  MOD_CTRL_CRC_EN defined:
//   - CRC-8 (poly 0x07, init 0x00, MSB-first, no reflect, no xorout) over the 2 header bytes and the payload.
//   - CRC state emits 1 byte between PAY and GUARD.
//  MOD_CTRL_CRC_EN undefined: no CRC state and no CRC logic; PAY -> GUARD directly.
// STRUCTURE
//  mod_ctrl_pkg:
//   - state_t enum {IDLE,PRE,HDR,PAY,CRC,GUARD}
//   - CRC8_POLY=8'h07, GUARD_BYTE=8'h00
//   - function crc8_step(crc, byte)
//  Sub-module mod_ctrl_crc8 (clear/enable/byte in, crc out), instantiated only under MOD_CTRL_CRC_EN.
//  Everything else is one FSM plus a byte counter and the output register in this file.
// TESTING
//  1 length=3, data A1 A2 A3, mod ready always -> 55 55 55 55 00 03 A1 A2 A3 00 00 on 11 consecutive cycles, o_done on last.
//  2 As 1 with MOD_CTRL_CRC_EN -> CRC-8 byte of {00,03,A1,A2,A3} inserted after A3; check vs reference model; then 00 00.
//  3 i_mod_ready toggling 1010.. -> identical byte sequence; o_mod_data stable through every stall.
//  4 Source withholds i_valid 5 cycles mid-payload -> bubbles on o_mod_valid, o_underrun_cnt=5, sequence intact.
//  5 i_abort during 2nd payload byte -> o_mod_valid=0 next cycle, o_aborted=1, o_done never; new i_start accepted after.
//  6 i_start with length=0 -> o_error pulse, o_busy stays 0; i_reset_n low mid-header -> all outputs 0 immediately.

Source files
------------

// File: rtl/mod_ctrl_pkg.sv
// Shared state encoding, constants and CRC-8 step function for the modulator frame controller.
package mod_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        PAY,
        CRC,
        GUARD
    } state_t;

    localparam logic [7:0] CRC8_POLY  = 8'h07;
    localparam logic [7:0] GUARD_BYTE = 8'h00;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/mod_ctrl_crc8.sv
// Running CRC-8 over the header and payload bytes; only built when MOD_CTRL_CRC_EN is defined.
`ifdef MOD_CTRL_CRC_EN
module mod_ctrl_crc8
    import mod_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (enable) begin
            crc <= crc8_step(crc, data);
        end
    end

endmodule
`endif

// File: rtl/modulator_frame_ctrl.sv
// Frame sequencer feeding the Modulator byte link: preamble, length header, payload,
// optional CRC-8 (enabled by MOD_CTRL_CRC_EN) and guard padding.
module modulator_frame_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int         LEN_W         = 16,
    parameter int         PREAMBLE_LEN  = 4,
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter int         GUARD_LEN     = 2,
    parameter int         UNDR_W        = 16
)(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_length,
    input  logic              i_abort,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [7:0]        o_mod_data,
    output logic              o_mod_valid,
    input  logic              i_mod_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic              o_error,
    output logic [UNDR_W-1:0] o_underrun_cnt
);

`ifdef MOD_CTRL_CRC_EN
    localparam state_t AFTER_PAY  = CRC;
    localparam state_t LAST_STATE = (GUARD_LEN > 0) ? GUARD : CRC;
`else
    localparam state_t AFTER_PAY  = GUARD;
    localparam state_t LAST_STATE = (GUARD_LEN > 0) ? GUARD : PAY;
`endif

    state_t              state_q, state_d, ld_state, nxt;
    logic [LEN_W-1:0]    cnt_q, cnt_d, len_q, len_d, ld_cnt;
    logic [15:0]         len16;
    logic                out_free, load;
    logic [7:0]          ld_byte, data_d;
    logic                valid_d, aborted_d, error_d;
    logic [UNDR_W-1:0]   undr_d;

`ifdef MOD_CTRL_CRC_EN
    logic       crc_clear, crc_en;
    logic [7:0] crc_val;

    mod_ctrl_crc8 u_crc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clear     (crc_clear),
        .enable    (crc_en),
        .data      (ld_byte),
        .crc       (crc_val)
    );
`endif

    assign len16    = 16'(len_q);
    assign out_free = !o_mod_valid || i_mod_ready;
    assign o_ready  = (state_q == PAY) && out_free && (cnt_q != '0);
    assign o_busy   = (state_q != IDLE);

    // cnt_q counts bytes of the current state still to be loaded; the last state
    // parks at zero until its final byte is accepted by the Modulator.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        data_d    = o_mod_data;
        valid_d   = o_mod_valid && !out_free;
        aborted_d = 1'b0;
        error_d   = 1'b0;
        undr_d    = o_underrun_cnt;
        o_done    = 1'b0;
        load      = 1'b0;
        ld_state  = state_q;
        ld_cnt    = cnt_q;
        nxt       = IDLE;
`ifdef MOD_CTRL_CRC_EN
        crc_clear = 1'b0;
        crc_en    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (i_length == '0) begin
                        error_d = 1'b1;
                    end else begin
                        load     = 1'b1;
                        ld_state = PRE;
                        ld_cnt   = LEN_W'(PREAMBLE_LEN);
                        len_d    = i_length;
`ifdef MOD_CTRL_CRC_EN
                        crc_clear = 1'b1;
`endif
                    end
                end
            end
            PAY: begin
                load = i_valid && o_ready;
                if (out_free && (cnt_q != '0) && !i_valid && (o_underrun_cnt != '1)) begin
                    undr_d = o_underrun_cnt + 1'b1;
                end
            end
            default: load = out_free && (cnt_q != '0);
        endcase

        case (ld_state)
            PRE:     ld_byte = PREAMBLE_BYTE;
            HDR:     ld_byte = (ld_cnt == LEN_W'(2)) ? len16[15:8] : len16[7:0];
            PAY:     ld_byte = i_data;
`ifdef MOD_CTRL_CRC_EN
            CRC:     ld_byte = crc_val;
`endif
            default: ld_byte = GUARD_BYTE;
        endcase

        if (load) begin
            data_d  = ld_byte;
            valid_d = 1'b1;
`ifdef MOD_CTRL_CRC_EN
            crc_en  = (ld_state == HDR) || (ld_state == PAY);
`endif
            if (ld_cnt > LEN_W'(1)) begin
                state_d = ld_state;
                cnt_d   = ld_cnt - 1'b1;
            end else if (ld_state == LAST_STATE) begin
                state_d = ld_state;
                cnt_d   = '0;
            end else begin
                case (ld_state)
                    PRE:     nxt = HDR;
                    HDR:     nxt = PAY;
                    PAY:     nxt = AFTER_PAY;
                    default: nxt = GUARD;
                endcase
                state_d = nxt;
                case (nxt)
                    HDR:     cnt_d = LEN_W'(2);
                    PAY:     cnt_d = len_q;
                    CRC:     cnt_d = LEN_W'(1);
                    default: cnt_d = LEN_W'(GUARD_LEN);
                endcase
            end
        end

        if ((state_q == LAST_STATE) && (cnt_q == '0) && o_mod_valid && i_mod_ready) begin
            o_done  = 1'b1;
            state_d = IDLE;
        end

        // Abort wins over everything, including a byte being loaded this cycle.
        if (i_abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            valid_d   = 1'b0;
            aborted_d = 1'b1;
            o_done    = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            len_q          <= '0;
            o_mod_data     <= 8'h00;
            o_mod_valid    <= 1'b0;
            o_aborted      <= 1'b0;
            o_error        <= 1'b0;
            o_underrun_cnt <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            len_q          <= len_d;
            o_mod_data     <= data_d;
            o_mod_valid    <= valid_d;
            o_aborted      <= aborted_d;
            o_error        <= error_d;
            o_underrun_cnt <= undr_d;
        end
    end

endmodule

// File: tb/tb_modulator_frame_ctrl.sv
// Scoreboard bench for modulator_frame_ctrl: stimulus queues expected link bytes,
// a falling-edge monitor pops and compares each accepted byte.
module tb_modulator_frame_ctrl;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_length = 16'h0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  o_mod_data;
    logic        o_mod_valid;
    logic        i_mod_ready = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic        o_error;
    logic [15:0] o_underrun_cnt;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         done_seen = 0;
    int         cyc_n = 0;
    int         first_cyc = -1;
    int         last_cyc = -1;
    bit         toggle_mode = 1'b0;
    logic [7:0] pay[0:7];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

`ifdef MOD_CTRL_CRC_EN
    localparam int CRC_BYTES = 1;

    // Bit-serial reference CRC-8, poly 0x07.
    function automatic logic [7:0] refCrc(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            fb = r[7] ^ b[k];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction
`else
    localparam int CRC_BYTES = 0;
`endif

    modulator_frame_ctrl dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_start        (i_start),
        .i_length       (i_length),
        .i_abort        (i_abort),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_mod_data     (o_mod_data),
        .o_mod_valid    (o_mod_valid),
        .i_mod_ready    (i_mod_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_aborted      (o_aborted),
        .o_error        (o_error),
        .o_underrun_cnt (o_underrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [7:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_mod_ready = toggle_mode ? ~i_mod_ready : 1'b1;
        end
    end

    // Monitor: every accepted byte must match the queue head, o_done only on the final byte.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            cyc_n++;
            if (!i_reset_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(o_mod_valid), 32'd1);
                checkOutput("stall_data", 32'(o_mod_data), 32'(prev_data));
            end
            if (o_mod_valid && i_mod_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_byte", 32'(o_mod_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("link_byte", 32'(o_mod_data), 32'(e.data));
                    checkOutput("done_flag", 32'(o_done), 32'(e.last));
                    if (first_cyc < 0) first_cyc = cyc_n;
                    last_cyc = cyc_n;
                end
            end else if (o_done) begin
                checkOutput("done_no_xfer", 32'(o_done), 32'd0);
            end
            if (o_done) done_seen++;
            prev_stall = o_mod_valid && !i_mod_ready;
            prev_data  = o_mod_data;
        end
    end

    // Runs one frame; gap_at/gap_len withhold i_valid, abort_at raises i_abort when that payload byte is offered.
    task automatic applyStimulus(input int len, input int gap_at, input int gap_len, input int abort_at);
        int          idx;
        int          gap;
        int          cyc;
        int          done0;
        logic [15:0] l16;
        logic [7:0]  crc;
        l16       = 16'(len);
        done0     = done_seen;
        first_cyc = -1;
        last_cyc  = -1;
        crc       = 8'h00;
        for (int i = 0; i < 4; i++) pushExp(8'h55, 1'b0);
        pushExp(l16[15:8], 1'b0);
        pushExp(l16[7:0], 1'b0);
        if (abort_at >= 0) begin
            for (int i = 0; i < abort_at; i++) pushExp(pay[i], 1'b0);
        end else begin
            for (int i = 0; i < len; i++) pushExp(pay[i], 1'b0);
`ifdef MOD_CTRL_CRC_EN
            crc = refCrc(crc, l16[15:8]);
            crc = refCrc(crc, l16[7:0]);
            for (int i = 0; i < len; i++) crc = refCrc(crc, pay[i]);
            pushExp(crc, 1'b0);
`endif
            pushExp(8'h00, 1'b0);
            pushExp(8'h00, 1'b1);
        end

        i_start  = 1'b1;
        i_length = l16;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        idx = 0;
        gap = gap_len;
        cyc = 0;
        while (idx < len && cyc < 200) begin
            if (idx == gap_at && gap > 0) begin
                i_valid = 1'b0;
                gap--;
            end else begin
                i_valid = 1'b1;
                i_data  = pay[idx];
            end
            if (idx == abort_at) i_abort = 1'b1;
            @(negedge i_clk);
            if (i_abort) break;
            if (i_valid && o_ready) idx++;
            @(posedge i_clk);
            #1;
            cyc++;
        end

        if (abort_at >= 0) begin
            @(posedge i_clk);
            #1;
            i_abort = 1'b0;
            i_valid = 1'b0;
            @(negedge i_clk);
            checkOutput("abort_valid", 32'(o_mod_valid), 32'd0);
            checkOutput("abort_pulse", 32'(o_aborted), 32'd1);
            checkOutput("abort_busy", 32'(o_busy), 32'd0);
            checkOutput("abort_ready", 32'(o_ready), 32'd0);
            @(negedge i_clk);
            checkOutput("abort_pulse_end", 32'(o_aborted), 32'd0);
        end else begin
            i_valid = 1'b0;
            checkOutput("src_bytes", 32'(idx), 32'(len));
            cyc = 0;
            while (sb.size() > 0 && cyc < 200) begin
                @(posedge i_clk);
                cyc++;
            end
            @(negedge i_clk);
            @(posedge i_clk);
            #1;
            checkOutput("busy_after", 32'(o_busy), 32'd0);
        end
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("done_count", 32'(done_seen - done0), (abort_at >= 0) ? 32'd0 : 32'd1);
    endtask

    initial begin
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3; pay[3] = 8'hA4;
        pay[4] = 8'hA5; pay[5] = 8'hA6; pay[6] = 8'hA7; pay[7] = 8'hA8;
        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rst_valid", 32'(o_mod_valid), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        checkOutput("rst_undr", 32'(o_underrun_cnt), 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic frame, Modulator always ready: bytes on consecutive cycles.
        applyStimulus(3, -1, 0, -1);
        checkOutput("t1_span", 32'(last_cyc - first_cyc), 32'(10 + CRC_BYTES));

        // Modulator ready toggling.
        toggle_mode = 1'b1;
        applyStimulus(3, -1, 0, -1);
        toggle_mode = 1'b0;
        checkOutput("t3_undr", 32'(o_underrun_cnt), 32'd0);

        // Source stalls 5 cycles mid-payload.
        pay[0] = 8'hB1; pay[1] = 8'hB2; pay[2] = 8'hB3;
        pay[3] = 8'hB4; pay[4] = 8'hB5; pay[5] = 8'hB6;
        @(posedge i_clk);
        #1;
        applyStimulus(6, 2, 5, -1);
        checkOutput("t4_undr", 32'(o_underrun_cnt), 32'd5);

        // Abort on the second payload byte, then a clean frame.
        applyStimulus(4, -1, 0, 1);
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        @(posedge i_clk);
        #1;
        applyStimulus(3, -1, 0, -1);
        checkOutput("t5_undr", 32'(o_underrun_cnt), 32'd5);

        // Zero-length start.
        i_start  = 1'b1;
        i_length = 16'h0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        @(negedge i_clk);
        checkOutput("err_pulse", 32'(o_error), 32'd1);
        checkOutput("err_busy", 32'(o_busy), 32'd0);
        checkOutput("err_valid", 32'(o_mod_valid), 32'd0);
        @(negedge i_clk);
        checkOutput("err_pulse_end", 32'(o_error), 32'd0);

        // Reset asserted while the first header byte sits in the output register.
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 4; i++) pushExp(8'h55, 1'b0);
        i_start  = 1'b1;
        i_length = 16'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        checkOutput("pre_rst_hdr", 32'(o_mod_data), 32'h00);
        checkOutput("pre_rst_valid", 32'(o_mod_valid), 32'd1);
        i_reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(o_mod_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(o_ready), 32'd0);
        checkOutput("mid_rst_done", 32'(o_done), 32'd0);
        checkOutput("mid_rst_undr", 32'(o_underrun_cnt), 32'd0);
        checkOutput("mid_rst_sb", 32'(sb.size()), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
